// File: rtl/esp_dma_pkg.sv
// Shared definitions for the ESP DMA memory responder.
// Holds DMA size encodings, the responder state enum, beat geometry and the
// ctrl-request payload struct carried on the dma_*_ctrl channels.
package esp_dma_pkg;

   localparam int unsigned BUS_WIDTH  = 64;
   localparam int unsigned WORD_WIDTH = 32;
   localparam int unsigned BEAT_WORDS = 2;
   localparam int unsigned IDX_WIDTH  = 32;
   localparam int unsigned LEN_WIDTH  = 32;
   localparam int unsigned SIZE_WIDTH = 3;

   localparam logic [SIZE_WIDTH-1:0] SIZE_BYTE  = 3'b000;
   localparam logic [SIZE_WIDTH-1:0] SIZE_HWORD = 3'b001;
   localparam logic [SIZE_WIDTH-1:0] SIZE_WORD  = 3'b010;
   localparam logic [SIZE_WIDTH-1:0] SIZE_DWORD = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_BURST = 2'd1,
      ST_WR_BURST = 2'd2
   } state_e;

   typedef struct packed {
      logic [IDX_WIDTH-1:0]  index;
      logic [LEN_WIDTH-1:0]  length;
      logic [SIZE_WIDTH-1:0] size;
   } dma_ctrl_t;

   // Only 32- and 64-bit element sizes match the fixed two-words-per-beat packing.
   function automatic logic size_supported(input logic [SIZE_WIDTH-1:0] size);
      logic ok;
      case (size)
         SIZE_BYTE, SIZE_HWORD: ok = 1'b0;
         SIZE_WORD, SIZE_DWORD: ok = 1'b1;
         default:               ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/esp_dma_mem_responder_if.sv
// DMA channel bundle between an ESP accelerator and the host-side responder.
//   dma_read_ctrl_*  : read request (valid/data/ready)
//   dma_read_chnl_*  : read beats toward the accelerator
//   dma_write_ctrl_* : write request (valid/data/ready)
//   dma_write_chnl_* : write beats from the accelerator
// Modports: slave = responder side, master = accelerator side.
interface esp_dma_mem_responder_if;
   import esp_dma_pkg::*;

   logic                 dma_read_ctrl_valid;
   dma_ctrl_t            dma_read_ctrl_data;
   logic                 dma_read_ctrl_ready;
   logic                 dma_read_chnl_valid;
   logic [BUS_WIDTH-1:0] dma_read_chnl_data;
   logic                 dma_read_chnl_ready;

   logic                 dma_write_ctrl_valid;
   dma_ctrl_t            dma_write_ctrl_data;
   logic                 dma_write_ctrl_ready;
   logic                 dma_write_chnl_valid;
   logic [BUS_WIDTH-1:0] dma_write_chnl_data;
   logic                 dma_write_chnl_ready;

   modport slave (
      input  dma_read_ctrl_valid, dma_read_ctrl_data, dma_read_chnl_ready,
      output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
      input  dma_write_ctrl_valid, dma_write_ctrl_data,
      input  dma_write_chnl_valid, dma_write_chnl_data,
      output dma_write_ctrl_ready, dma_write_chnl_ready
   );

   modport master (
      output dma_read_ctrl_valid, dma_read_ctrl_data, dma_read_chnl_ready,
      input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
      output dma_write_ctrl_valid, dma_write_ctrl_data,
      output dma_write_chnl_valid, dma_write_chnl_data,
      input  dma_write_ctrl_ready, dma_write_chnl_ready
   );

endinterface

// File: rtl/esp_dma_word_mem.sv
// Word-addressed memory with a two-word DMA port and a one-word backdoor port.
//   clk_i        : clock
//   dma_we_i     : write the beat at dma_addr_i / dma_addr_i+1 (wrapping)
//   dma_addr_i   : DMA word address (low word of the beat)
//   dma_wdata_i  : beat to write, {hi word, lo word}
//   dma_rdata_o  : combinational beat read {mem[addr+1], mem[addr]}
//   host_we_i    : backdoor write strobe
//   host_addr_i  : backdoor word address
//   host_wdata_i : backdoor write data
//   host_rdata_o : combinational backdoor read
// Contents are intentionally not reset.
module esp_dma_word_mem
   import esp_dma_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 32,
   parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
   input  logic                             clk_i,
   input  logic                             dma_we_i,
   input  logic [AW-1:0]                    dma_addr_i,
   input  logic [BEAT_WORDS*WORD_WIDTH-1:0] dma_wdata_i,
   output logic [BEAT_WORDS*WORD_WIDTH-1:0] dma_rdata_o,
   input  logic                             host_we_i,
   input  logic [AW-1:0]                    host_addr_i,
   input  logic [WORD_WIDTH-1:0]            host_wdata_i,
   output logic [WORD_WIDTH-1:0]            host_rdata_o
);

   logic [WORD_WIDTH-1:0] mem_q [MEM_WORDS];
   logic [AW-1:0]         dma_addr_hi;

   assign dma_addr_hi = AW'(dma_addr_i + AW'(1));

   // DMA write is issued last so it overrides a same-word backdoor write.
   always_ff @(posedge clk_i) begin
      if (host_we_i) begin
         mem_q[host_addr_i] <= host_wdata_i;
      end
      if (dma_we_i) begin
         mem_q[dma_addr_i]  <= dma_wdata_i[WORD_WIDTH-1:0];
         mem_q[dma_addr_hi] <= dma_wdata_i[2*WORD_WIDTH-1:WORD_WIDTH];
      end
   end

   assign dma_rdata_o  = {mem_q[dma_addr_hi], mem_q[dma_addr_i]};
   assign host_rdata_o = mem_q[host_addr_i];

endmodule

// File: rtl/esp_dma_mem_responder.sv
// Host-side DMA responder / memory model for ESP RTL accelerators.
// Serves read and write bursts of 64-bit beats from a 32-bit word memory.
//   clk, rst   : clock, asynchronous active-high reset
//   dma        : DMA ctrl/chnl bundle (slave modport)
//   host_we    : backdoor write strobe
//   host_addr  : backdoor word address
//   host_wdata : backdoor write data
//   host_rdata : combinational read of mem[host_addr]
//   busy       : a burst is in progress
//   err        : sticky error (unsupported size or address wrap)
// Optional build macro ESP_DMA_RESP_STALL_EN inserts a one-cycle bubble after
// every accepted beat and after each burst before the next ctrl accept.
module esp_dma_mem_responder
   import esp_dma_pkg::*;
#(
   parameter int unsigned DMA_BUS_WIDTH = 64,
   parameter int unsigned MEM_WORDS     = 32,
   parameter int unsigned AW            = $clog2(MEM_WORDS)
) (
   input  logic                  clk,
   input  logic                  rst,
   esp_dma_mem_responder_if.slave dma,
   input  logic                  host_we,
   input  logic [AW-1:0]         host_addr,
   input  logic [WORD_WIDTH-1:0] host_wdata,
   output logic [WORD_WIDTH-1:0] host_rdata,
   output logic                  busy,
   output logic                  err
);

   state_e                 state_q, state_d;
   logic [AW-1:0]          ptr_q, ptr_d;
   logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   wrap_q, wrap_d;
   logic                   err_q, err_d;
   logic                   stall_q;
   logic [AW:0]            ptr_sum;
   dma_ctrl_t              acc_ctrl;
   logic [IDX_WIDTH:0]     acc_idx2;
   logic                   rd_ctrl_ready_c, wr_ctrl_ready_c;
   logic                   rd_valid_c, wr_ready_c, beat_c, mem_we_c;
   logic [DMA_BUS_WIDTH-1:0] mem_rdata;

   // Carry out of the pointer step marks that later beats start past the end.
   assign ptr_sum = {1'b0, ptr_q} + (AW+1)'(BEAT_WORDS);

   // Next state, pointer/counter updates and handshake outputs.
   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      cnt_d           = cnt_q;
      wrap_d          = wrap_q;
      err_d           = err_q;
      rd_ctrl_ready_c = 1'b0;
      wr_ctrl_ready_c = 1'b0;
      rd_valid_c      = 1'b0;
      wr_ready_c      = 1'b0;
      beat_c          = 1'b0;
      mem_we_c        = 1'b0;
      acc_ctrl        = dma.dma_read_ctrl_valid ? dma.dma_read_ctrl_data
                                                : dma.dma_write_ctrl_data;
      acc_idx2        = {acc_ctrl.index, 1'b0};

      case (state_q)
         ST_IDLE: begin
            rd_ctrl_ready_c = !rst && !stall_q;
            wr_ctrl_ready_c = !rst && !stall_q && !dma.dma_read_ctrl_valid;
            if ((dma.dma_read_ctrl_valid && rd_ctrl_ready_c) ||
                (dma.dma_write_ctrl_valid && wr_ctrl_ready_c)) begin
               ptr_d  = acc_idx2[AW-1:0];
               cnt_d  = acc_ctrl.length;
               wrap_d = |acc_idx2[IDX_WIDTH:AW];
               if (!size_supported(acc_ctrl.size)) begin
                  err_d = 1'b1;
               end
               if (acc_ctrl.length != '0) begin
                  state_d = dma.dma_read_ctrl_valid ? ST_RD_BURST : ST_WR_BURST;
               end
            end
         end
         ST_RD_BURST: begin
            rd_valid_c = !stall_q;
            beat_c     = rd_valid_c && dma.dma_read_chnl_ready;
         end
         ST_WR_BURST: begin
            wr_ready_c = !stall_q;
            beat_c     = wr_ready_c && dma.dma_write_chnl_valid;
            mem_we_c   = beat_c;
         end
         default: state_d = ST_IDLE;
      endcase

      // A beat whose unwrapped start lies past the array flags err but still proceeds.
      if (beat_c) begin
         ptr_d  = ptr_sum[AW-1:0];
         cnt_d  = cnt_q - LEN_WIDTH'(1);
         wrap_d = wrap_q | ptr_sum[AW];
         if (wrap_q) begin
            err_d = 1'b1;
         end
         if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = ST_IDLE;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

`ifdef ESP_DMA_RESP_STALL_EN
   // Bubble flop: high for exactly one cycle after each accepted beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= 1'b0;
      end else begin
         stall_q <= beat_c;
      end
   end
`else
   assign stall_q = 1'b0;
`endif

   esp_dma_word_mem #(
      .MEM_WORDS (MEM_WORDS),
      .AW        (AW)
   ) u_mem (
      .clk_i        (clk),
      .dma_we_i     (mem_we_c),
      .dma_addr_i   (ptr_q),
      .dma_wdata_i  (dma.dma_write_chnl_data),
      .dma_rdata_o  (mem_rdata),
      .host_we_i    (host_we),
      .host_addr_i  (host_addr),
      .host_wdata_i (host_wdata),
      .host_rdata_o (host_rdata)
   );

   assign dma.dma_read_ctrl_ready  = rd_ctrl_ready_c;
   assign dma.dma_write_ctrl_ready = wr_ctrl_ready_c;
   assign dma.dma_read_chnl_valid  = rd_valid_c;
   assign dma.dma_write_chnl_ready = wr_ready_c;
   assign dma.dma_read_chnl_data   = (state_q == ST_RD_BURST) ? mem_rdata : '0;
   assign busy                     = (state_q != ST_IDLE);
   assign err                      = err_q;

endmodule

// File: tb/tb_esp_dma_mem_responder.sv
// Directed bench for esp_dma_mem_responder: backdoor preload, read/write
// bursts, arbitration, zero length, wrap, back-pressure and mid-burst reset.
module tb_esp_dma_mem_responder;
   import esp_dma_pkg::*;

   localparam int MW = 32;
   localparam int AW = 5;
`ifdef ESP_DMA_RESP_STALL_EN
   localparam int STALL_GAP = 1;
`else
   localparam int STALL_GAP = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [31:0]   host_wdata;
   logic [31:0]   host_rdata;
   logic          busy;
   logic          err;

   logic [31:0] model [MW];
   logic [31:0] prog [16] = '{32'h00008E30, 32'hFF02009F, 32'h00000513, 32'h00100593,
                              32'h00B50633, 32'h00C12023, 32'h00410113, 32'hFE069AE3,
                              32'h0000006F, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F,
                              32'hF0F0F0F0, 32'hDEADBEEF, 32'hCAFEBABE, 32'h00000001};
   int n_checks = 0;
   int n_fail   = 0;

   esp_dma_mem_responder_if dma_if ();

   esp_dma_mem_responder #(
      .DMA_BUS_WIDTH (64),
      .MEM_WORDS     (MW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .dma        (dma_if.slave),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [63:0] beat_exp(input int idx, input int k);
      int a;
      a = (2 * (idx + k)) % MW;
      return {model[(a + 1) % MW], model[a]};
   endfunction

   task automatic host_wr(input int a, input logic [31:0] d);
      host_we    = 1'b1;
      host_addr  = AW'(a);
      host_wdata = d;
      tick();
      host_we    = 1'b0;
      model[a]   = d;
   endtask

   task automatic host_chk(input string tag, input int a);
      host_addr = AW'(a);
      #1;
      check(tag, 64'(host_rdata), 64'(model[a]));
   endtask

   task automatic rd_req(input int idx, input int len, input logic [2:0] sz, input string tag);
      dma_if.dma_read_ctrl_valid        = 1'b1;
      dma_if.dma_read_ctrl_data.index  = 32'(idx);
      dma_if.dma_read_ctrl_data.length = 32'(len);
      dma_if.dma_read_ctrl_data.size   = sz;
      #1;
      check({tag, "_ctrl_rdy"}, 64'(dma_if.dma_read_ctrl_ready), 64'd1);
      tick();
      dma_if.dma_read_ctrl_valid = 1'b0;
   endtask

   task automatic wr_req(input int idx, input int len, input logic [2:0] sz, input string tag);
      dma_if.dma_write_ctrl_valid        = 1'b1;
      dma_if.dma_write_ctrl_data.index  = 32'(idx);
      dma_if.dma_write_ctrl_data.length = 32'(len);
      dma_if.dma_write_ctrl_data.size   = sz;
      #1;
      check({tag, "_ctrl_rdy"}, 64'(dma_if.dma_write_ctrl_ready), 64'd1);
      tick();
      dma_if.dma_write_ctrl_valid = 1'b0;
   endtask

   // Consume len beats with chnl_ready high; bubbles only expected between beats.
   task automatic rd_beats(input int idx, input int len, input string tag);
      int w;
      for (int k = 0; k < len; k++) begin
         w = 0;
         #1;
         while (!dma_if.dma_read_chnl_valid && w < 4) begin
            tick();
            #1;
            w++;
         end
         check({tag, "_gap"}, 64'(w), (k == 0) ? 64'd0 : 64'(STALL_GAP));
         check({tag, "_data"}, dma_if.dma_read_chnl_data, beat_exp(idx, k));
         tick();
      end
      #1;
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
      check({tag, "_valid_end"}, 64'(dma_if.dma_read_chnl_valid), 64'd0);
   endtask

   // Write back each beat with both words doubled.
   task automatic wr_beats(input int idx, input int len, input string tag);
      int w, a;
      logic [31:0] lo, hi;
      for (int k = 0; k < len; k++) begin
         a  = (2 * (idx + k)) % MW;
         lo = model[a] * 2;
         hi = model[(a + 1) % MW] * 2;
         dma_if.dma_write_chnl_valid = 1'b1;
         dma_if.dma_write_chnl_data  = {hi, lo};
         #1;
         w = 0;
         while (!dma_if.dma_write_chnl_ready && w < 4) begin
            tick();
            #1;
            w++;
         end
         check({tag, "_gap"}, 64'(w), (k == 0) ? 64'd0 : 64'(STALL_GAP));
         tick();
         model[a]            = lo;
         model[(a + 1) % MW] = hi;
      end
      dma_if.dma_write_chnl_valid = 1'b0;
      #1;
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      #1;
      check("rst_err_clr", 64'(err), 64'd0);
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      rst        = 1'b1;
      host_we    = 1'b0;
      host_addr  = '0;
      host_wdata = '0;
      dma_if.dma_read_ctrl_valid  = 1'b0;
      dma_if.dma_read_ctrl_data   = '0;
      dma_if.dma_read_chnl_ready  = 1'b1;
      dma_if.dma_write_ctrl_valid = 1'b1;
      dma_if.dma_write_ctrl_data  = '0;
      dma_if.dma_write_chnl_valid = 1'b0;
      dma_if.dma_write_chnl_data  = '0;

      // Reset values
      repeat (2) tick();
      check("rst_rd_ctrl_rdy", 64'(dma_if.dma_read_ctrl_ready), 64'd0);
      check("rst_wr_ctrl_rdy", 64'(dma_if.dma_write_ctrl_ready), 64'd0);
      check("rst_rd_valid", 64'(dma_if.dma_read_chnl_valid), 64'd0);
      check("rst_wr_chnl_rdy", 64'(dma_if.dma_write_chnl_ready), 64'd0);
      check("rst_rd_data", dma_if.dma_read_chnl_data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      dma_if.dma_write_ctrl_valid = 1'b0;
      rst = 1'b0;
      tick();

      // Backdoor preload
      for (int i = 0; i < 16; i++) host_wr(i, prog[i]);
      for (int i = 0; i < 16; i++) host_wr(16 + i, 32'(i + 1));
      host_chk("bd_rd0", 0);
      host_chk("bd_rd31", 31);

      // Program read
      rd_req(0, 8, SIZE_WORD, "prog");
      #1;
      check("prog_beat0_const", dma_if.dma_read_chnl_data, 64'hFF02009F_00008E30);
      check("prog_busy", 64'(busy), 64'd1);
      rd_beats(0, 8, "prog");

      // Data round trip
      repeat (2) tick();
      rd_req(8, 4, SIZE_DWORD, "rt_rd");
      #1;
      check("rt_beat0_const", dma_if.dma_read_chnl_data, 64'h00000002_00000001);
      rd_beats(8, 4, "rt_rd");
      repeat (2) tick();
      wr_req(8, 4, SIZE_DWORD, "rt_wr");
      wr_beats(8, 4, "rt_wr");
      for (int i = 16; i < 24; i++) host_chk("rt_mem", i);
      host_addr = AW'(23);
      #1;
      check("rt_mem23_const", 64'(host_rdata), 64'd16);
      host_addr = AW'(24);
      #1;
      check("rt_mem24_untouched", 64'(host_rdata), 64'd9);

      // Simultaneous requests: read wins, write waits for the burst
      repeat (2) tick();
      dma_if.dma_read_ctrl_valid        = 1'b1;
      dma_if.dma_read_ctrl_data.index  = 32'd0;
      dma_if.dma_read_ctrl_data.length = 32'd2;
      dma_if.dma_read_ctrl_data.size   = SIZE_WORD;
      dma_if.dma_write_ctrl_valid        = 1'b1;
      dma_if.dma_write_ctrl_data.index  = 32'd12;
      dma_if.dma_write_ctrl_data.length = 32'd1;
      dma_if.dma_write_ctrl_data.size   = SIZE_WORD;
      #1;
      check("simul_rd_rdy", 64'(dma_if.dma_read_ctrl_ready), 64'd1);
      check("simul_wr_rdy", 64'(dma_if.dma_write_ctrl_ready), 64'd0);
      tick();
      dma_if.dma_read_ctrl_valid = 1'b0;
      #1;
      check("simul_wr_rdy_busy", 64'(dma_if.dma_write_ctrl_ready), 64'd0);
      rd_beats(0, 2, "simul_rd");
      check("simul_wr_rdy_first", 64'(dma_if.dma_write_ctrl_ready), (STALL_GAP == 0) ? 64'd1 : 64'd0);
      repeat (STALL_GAP) begin
         tick();
         #1;
      end
      check("simul_wr_rdy", 64'(dma_if.dma_write_ctrl_ready), 64'd1);
      tick();
      dma_if.dma_write_ctrl_valid = 1'b0;
      wr_beats(12, 1, "simul_wr");
      host_chk("simul_mem24", 24);
      host_chk("simul_mem25", 25);

      // Zero length
      repeat (2) tick();
      rd_req(3, 0, SIZE_WORD, "len0_rd");
      #1;
      check("len0_rd_busy", 64'(busy), 64'd0);
      check("len0_rd_valid", 64'(dma_if.dma_read_chnl_valid), 64'd0);
      tick();
      check("len0_rd_busy2", 64'(busy), 64'd0);
      wr_req(3, 0, SIZE_WORD, "len0_wr");
      #1;
      check("len0_wr_busy", 64'(busy), 64'd0);
      check("len0_wr_chnl_rdy", 64'(dma_if.dma_write_chnl_ready), 64'd0);

      // Wrap from word 30 to word 0
      repeat (2) tick();
      check("wrap_err_pre", 64'(err), 64'd0);
      rd_req(15, 2, SIZE_WORD, "wrap");
      #1;
      check("wrap_beat0_const", dma_if.dma_read_chnl_data, 64'h00000010_0000000F);
      check("wrap_err_beat0", 64'(err), 64'd0);
      rd_beats(15, 2, "wrap");
      check("wrap_err", 64'(err), 64'd1);
      rst_pulse();

      // Unsupported size still served, err set
      rd_req(0, 1, SIZE_BYTE, "badsz");
      #1;
      check("badsz_err", 64'(err), 64'd1);
      rd_beats(0, 1, "badsz");
      rst_pulse();

      // Back-pressure for 3 cycles after the first beat
      rd_req(4, 4, SIZE_WORD, "bp");
      #1;
      check("bp_beat0", dma_if.dma_read_chnl_data, beat_exp(4, 0));
      tick();
      dma_if.dma_read_chnl_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (c >= STALL_GAP) begin
            check("bp_hold_valid", 64'(dma_if.dma_read_chnl_valid), 64'd1);
            check("bp_hold_data", dma_if.dma_read_chnl_data, beat_exp(4, 1));
         end
         tick();
      end
      dma_if.dma_read_chnl_ready = 1'b1;
      rd_beats(5, 3, "bp_rest");

      // Reset mid-burst
      repeat (2) tick();
      rd_req(0, 8, SIZE_WORD, "mid");
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 64'(dma_if.dma_read_chnl_valid), 64'd0);
      check("mid_rst_data", dma_if.dma_read_chnl_data, 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_ctrl_rdy", 64'(dma_if.dma_read_ctrl_ready), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      host_chk("mid_rst_mem_kept", 1);
      rd_req(2, 2, SIZE_WORD, "after_rst");
      rd_beats(2, 2, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/esp_dma_mem_responder.md
Name: esp_dma_mem_responder

Overview:
- Synthesizable host-side DMA responder (memory model) for ESP RTL accelerators such as espacc_rtl_basic_dma.
- Accepts read/write control requests on the accelerator's dma_read_ctrl / dma_write_ctrl interfaces.
- Streams 64-bit beats out of an internal 32-bit word memory, or captures beats into it.
- Has a backdoor port so the bench or SoC glue can preload the program and data and inspect results.

Parameters:
- DMA_BUS_WIDTH, 64, channel data width; only 64 is supported.
- MEM_WORDS, 32, depth of the 32-bit word memory; must be a power of two, at least 2.
- AW, $clog2(MEM_WORDS), word address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- dma_read_ctrl_valid  in  1  accelerator read request
- dma_read_ctrl_data_index  in  32  start beat index
- dma_read_ctrl_data_length  in  32  number of beats
- dma_read_ctrl_data_size  in  3  element size; 010 = WORD, 011 = DWORD
- dma_read_ctrl_ready  out  1  read request accepted
- dma_read_chnl_valid  out  1  read beat valid
- dma_read_chnl_data  out  64  read beat data
- dma_read_chnl_ready  in  1  accelerator takes beat
- dma_write_ctrl_valid / _data_index / _data_length / _data_size  in  1/32/32/3  same fields as the read side
- dma_write_ctrl_ready  out  1  write request accepted
- dma_write_chnl_valid  in  1  write beat valid
- dma_write_chnl_data  in  64  write beat data
- dma_write_chnl_ready  out  1  responder takes beat
- host_we  in  1  backdoor write strobe
- host_addr  in  AW  backdoor word address
- host_wdata  in  32  backdoor write data
- host_rdata  out  32  combinational read of mem[host_addr]
- busy  out  1  state is not IDLE
- err  out  1  sticky error flag

Behaviour:
- States: IDLE, RD_BURST, WR_BURST. Reset forces IDLE, clears all pointers and counters, sets err=0. Memory contents are not reset.
- Output values in reset: all ctrl_ready, chnl_valid and chnl_ready outputs 0; dma_read_chnl_data 0.
- Ready logic (combinational):
  - dma_read_ctrl_ready = (state==IDLE).
  - dma_write_ctrl_ready = (state==IDLE) & !dma_read_ctrl_valid, so reads win when both requests are valid in the same cycle.
- Ctrl accept: on valid&ready, latch ptr = index*2 (word address, low AW bits) and cnt = length. Next state is RD_BURST or WR_BURST; if length==0, stay in IDLE.
- Size check: if size is not 010 or 011, set err. The request is still served; packing is always two 32-bit words per beat.
- RD_BURST:
  - dma_read_chnl_valid=1.
  - dma_read_chnl_data = {mem[ptr+1], mem[ptr]}, read combinationally from the current pointer.
  - Each valid&ready: ptr += 2, cnt -= 1. The beat with cnt==1 returns the FSM to IDLE.
  - The first beat is available one cycle after ctrl accept.
- WR_BURST:
  - dma_write_chnl_ready=1.
  - Each valid&ready: mem[ptr] <= data[31:0], mem[ptr+1] <= data[63:32]; ptr += 2, cnt -= 1. The last beat returns the FSM to IDLE.
- Wrap-around: ptr arithmetic is modulo MEM_WORDS. Any beat whose start address is ≥ MEM_WORDS−1 before the wrap sets err; the access proceeds wrapped.
- Backdoor:
  - host_we writes mem[host_addr] in any state.
  - Same-cycle collision with a DMA write beat on the same word: the DMA write wins.
  - host_rdata reflects the current memory contents.
- A chnl_valid held low by either side stalls the burst indefinitely; no timeout.
- Asynchronous reset mid-burst abandons the burst; the next request starts clean.

Optional Feature:
- Macro: ESP_DMA_RESP_STALL_EN.
- Defined: a toggle flop inserts one bubble after every accepted beat.
  - In RD_BURST, dma_read_chnl_valid drops for one cycle after each handshake.
  - In WR_BURST, dma_write_chnl_ready drops for one cycle after each handshake.
  - Ctrl_ready is also withheld for the first IDLE cycle after a burst ends.
- Undefined: full-throughput, one beat per cycle, as described above.

Decomposition:
- Shared package esp_dma_pkg holds:
  - DMA size encodings (SIZE_BYTE=000, SIZE_HWORD=001, SIZE_WORD=010, SIZE_DWORD=011).
  - State enum localparams.
  - The BEAT_WORDS=2 constant.
- One sub-module, esp_dma_word_mem: dual-port word array. It has a DMA port (two-word write and two-word combinational read at ptr) and the backdoor port, with DMA priority on collision. The FSM and counters stay in the top module.

Test Plan:
- Program read:
  - Stimulus: backdoor-load mem[0..15] with 0x8E30, 0xFF02009F, ...; request read index 0, length 8, size 010, accelerator ready held high.
  - Required: ctrl_ready in the accept cycle; 8 consecutive beats, beat0 = {0xFF02009F, 0x8E30}; busy drops after beat 7.
- Data round trip:
  - Stimulus: mem[16..31] = 1..16; read index 8 length 4, write index 8 length 4 with data doubled.
  - Required: read beats {2,1}, {4,3}, {6,5}, {8,7}; afterwards mem[16..23] = 2, 4, ..., 16 via host_rdata.
- Simultaneous requests:
  - Stimulus: read and write ctrl valid in the same IDLE cycle.
  - Required: only dma_read_ctrl_ready=1; write is accepted one cycle after the read burst completes.
- Edge cases:
  - Length 0: busy never asserts and no chnl_valid.
  - Index 15, length 2: ptr wraps to word 0, err=1, and data {mem[1], mem[0]} appears on the second beat.
- Back-pressure and reset:
  - Accelerator drops chnl_ready for 3 cycles mid-burst: data and valid hold stable.
  - rst pulsed mid-burst: outputs go to 0 immediately and state returns to IDLE.
- With ESP_DMA_RESP_STALL_EN defined: 4-beat read takes 8 cycles with alternating valid; data order is unchanged.
